// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the parametrised VGA timing generator:
//   - standard mode timing sets (1024x768@60 and 640x480@60)
//   - sync polarity encodings
//   - helper to compute a line/frame total from its four segments
// No ports; imported by vga_timing_gen and vga_delay_line.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Sync polarity encodings (level driven while the pulse is asserted)
    localparam int SYNC_POL_NEG = 0;
    localparam int SYNC_POL_POS = 1;

    // Largest supported sync/DE delay relative to the coordinates
    localparam int MAX_PIPE_DLY = 15;

    // 1024x768 @ 60 Hz, 65 MHz pixel clock, both syncs negative
    localparam int M1024_H_ACTIVE = 1024;
    localparam int M1024_H_FP     = 24;
    localparam int M1024_H_SYNC   = 136;
    localparam int M1024_H_BP     = 160;
    localparam int M1024_V_ACTIVE = 768;
    localparam int M1024_V_FP     = 3;
    localparam int M1024_V_SYNC   = 6;
    localparam int M1024_V_BP     = 29;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int M640_H_ACTIVE  = 640;
    localparam int M640_H_FP      = 16;
    localparam int M640_H_SYNC    = 96;
    localparam int M640_H_BP      = 48;
    localparam int M640_V_ACTIVE  = 480;
    localparam int M640_V_FP      = 10;
    localparam int M640_V_SYNC    = 2;
    localparam int M640_V_BP      = 33;

    // Total length of a line or frame from its active/porch/sync segments
    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// DEPTH-stage register delay line with synchronous active-low clear.
// DEPTH = 0 degenerates to a plain wire.
// Ports:
//   clk     in   1      clock
//   rst_n   in   1      synchronous active-low clear of every stage
//   i_data  in   WIDTH  data entering the line
//   o_data  out  WIDTH  data delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module vga_delay_line
    import vga_timing_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and clear have no function without storage
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign o_data   = i_data;
        end else begin : g_regs
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift register; clear flushes every stage to the inactive value
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule : vga_delay_line

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA sync generator with a display window inside the active
// area. Window-relative coordinates leave one cycle after the counters; the
// sync and enable outputs follow PIPE_DLY cycles later so they line up with
// framebuffer data fetched using those coordinates.
// Ports:
//   clk          in   1      pixel clock
//   rst_n        in   1      synchronous active-low reset
//   hsync        out  1      horizontal sync (delayed, polarity H_SYNC_POL)
//   vsync        out  1      vertical sync (delayed, polarity V_SYNC_POL)
//   de           out  1      active-area data enable (delayed)
//   win_de       out  1      window data enable (delayed)
//   win_x        out  CNT_W  window-relative pixel (undelayed, 0 outside)
//   win_y        out  CNT_W  window-relative line (undelayed, 0 outside)
//   line_start   out  1      one-cycle pulse for h=0 (undelayed)
//   frame_start  out  1      one-cycle pulse for h=0,v=0 (undelayed)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = M1024_H_ACTIVE,
    parameter int H_FP       = M1024_H_FP,
    parameter int H_SYNC     = M1024_H_SYNC,
    parameter int H_BP       = M1024_H_BP,
    parameter int V_ACTIVE   = M1024_V_ACTIVE,
    parameter int V_FP       = M1024_V_FP,
    parameter int V_SYNC     = M1024_V_SYNC,
    parameter int V_BP       = M1024_V_BP,
    parameter int H_SYNC_POL = SYNC_POL_NEG,
    parameter int V_SYNC_POL = SYNC_POL_NEG,
    parameter int WIN_X0     = 0,
    parameter int WIN_Y0     = 128,
    parameter int WIN_W      = 1024,
    parameter int WIN_H      = 512,
    parameter int PIPE_DLY   = 2,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             win_de,
    output logic [CNT_W-1:0] win_x,
    output logic [CNT_W-1:0] win_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Decode boundaries at counter width; all are < 2^CNT_W once checked below
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] X0_C    = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] X1_C    = CNT_W'(WIN_X0 + WIN_W);
    localparam logic [CNT_W-1:0] Y0_C    = CNT_W'(WIN_Y0);
    localparam logic [CNT_W-1:0] Y1_C    = CNT_W'(WIN_Y0 + WIN_H);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam logic H_POL_C = (H_SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic V_POL_C = (V_SYNC_POL != 0) ? 1'b1 : 1'b0;

    // ---------------------------------------------------------------------
    // Parameter sanity, rejected at elaboration
    // ---------------------------------------------------------------------
    generate
        if ((WIN_X0 + WIN_W > H_ACTIVE) || (WIN_Y0 + WIN_H > V_ACTIVE)) begin : g_err_win
            $error("vga_timing_gen: display window exceeds the active area");
        end
        if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
            (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0)) begin : g_err_zero
            $error("vga_timing_gen: porch and sync widths must be non-zero");
        end
        if ((PIPE_DLY < 0) || (PIPE_DLY > MAX_PIPE_DLY)) begin : g_err_dly
            $error("vga_timing_gen: PIPE_DLY must be in 0..15");
        end
        if ((H_TOT >= (1 << CNT_W)) || (V_TOT >= (1 << CNT_W))) begin : g_err_cnt
            $error("vga_timing_gen: line/frame totals do not fit in CNT_W bits");
        end
    endgenerate

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;

    logic             w_act;
    logic             w_hs_a;
    logic             w_vs_a;
    logic             w_inside;

    logic [CNT_W-1:0] r_win_x;
    logic [CNT_W-1:0] r_win_y;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_de;
    logic             r_win_de;
    logic             r_hs;
    logic             r_vs;

    logic [3:0]       w_dly;

    // Raster position counters; v advances on the last pixel of each line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == V_LAST) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + ONE_C;
            end
        end else begin
            r_h_cnt <= r_h_cnt + ONE_C;
        end
    end

    // Stage 0: combinational decode of the current raster position
    assign w_act    = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
    assign w_hs_a   = (r_h_cnt >= H_SS_C) && (r_h_cnt < H_SE_C);
    assign w_vs_a   = (r_v_cnt >= V_SS_C) && (r_v_cnt < V_SE_C);
    assign w_inside = w_act &&
                      (r_h_cnt >= X0_C) && (r_h_cnt < X1_C) &&
                      (r_v_cnt >= Y0_C) && (r_v_cnt < Y1_C);

    // Stage 1: coordinates, start pulses and active-high sync/enable flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win_x       <= '0;
            r_win_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_de          <= 1'b0;
            r_win_de      <= 1'b0;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
        end else begin
            if (w_inside) begin
                r_win_x <= r_h_cnt - X0_C;
                r_win_y <= r_v_cnt - Y0_C;
            end else begin
                r_win_x <= '0;
                r_win_y <= '0;
            end
            r_line_start  <= (r_h_cnt == '0);
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_de          <= w_act;
            r_win_de      <= w_inside;
            r_hs          <= w_hs_a;
            r_vs          <= w_vs_a;
        end
    end

    // Flags travel active-high so a cleared stage always means "not asserted";
    // polarity is applied only at the pins.
    vga_delay_line #(
        .WIDTH (4),
        .DEPTH (PIPE_DLY)
    ) u_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({r_hs, r_vs, r_de, r_win_de}),
        .o_data (w_dly)
    );

    assign hsync       = w_dly[3] ? H_POL_C : ~H_POL_C;
    assign vsync       = w_dly[2] ? V_POL_C : ~V_POL_C;
    assign de          = w_dly[1];
    assign win_de      = w_dly[0];
    assign win_x       = r_win_x;
    assign win_y       = r_win_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule : vga_timing_gen

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Five generator instances sharing one clock and reset:
//   u_def  - defaults (1024x768, PIPE_DLY=2)
//   u_p0   - defaults with PIPE_DLY=0
//   u_p3   - defaults with PIPE_DLY=3
//   u_640  - 640x480, both sync polarities positive, full-screen window
//   u_tiny - 16x10 miniature mode (H 16/2/3/4, V 10/1/2/3), window at (4,3)
//            8x5, hsync negative, vsync positive, PIPE_DLY=3; small enough
//            to cover window edges and a frame wrap in a few hundred cycles.
// Cycle k counts posedges since rst_n rose; sampling is on the negedge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;

    logic d_hs, d_vs, d_de, d_wde, d_ls, d_fs;
    logic [10:0] d_wx, d_wy;
    logic p0_hs, p0_vs, p0_de, p0_wde, p0_ls, p0_fs;
    logic [10:0] p0_wx, p0_wy;
    logic p3_hs, p3_vs, p3_de, p3_wde, p3_ls, p3_fs;
    logic [10:0] p3_wx, p3_wy;
    logic m_hs, m_vs, m_de, m_wde, m_ls, m_fs;
    logic [10:0] m_wx, m_wy;
    logic t_hs, t_vs, t_de, t_wde, t_ls, t_fs;
    logic [10:0] t_wx, t_wy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .win_de(d_wde), .win_x(d_wx), .win_y(d_wy), .line_start(d_ls),
        .frame_start(d_fs));

    vga_timing_gen #(.PIPE_DLY(0)) u_p0 (
        .clk(clk), .rst_n(rst_n), .hsync(p0_hs), .vsync(p0_vs), .de(p0_de),
        .win_de(p0_wde), .win_x(p0_wx), .win_y(p0_wy), .line_start(p0_ls),
        .frame_start(p0_fs));

    vga_timing_gen #(.PIPE_DLY(3)) u_p3 (
        .clk(clk), .rst_n(rst_n), .hsync(p3_hs), .vsync(p3_vs), .de(p3_de),
        .win_de(p3_wde), .win_x(p3_wx), .win_y(p3_wy), .line_start(p3_ls),
        .frame_start(p3_fs));

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .H_SYNC_POL(1), .V_SYNC_POL(1),
        .WIN_X0(0), .WIN_Y0(0), .WIN_W(640), .WIN_H(480)
    ) u_640 (
        .clk(clk), .rst_n(rst_n), .hsync(m_hs), .vsync(m_vs), .de(m_de),
        .win_de(m_wde), .win_x(m_wx), .win_y(m_wy), .line_start(m_ls),
        .frame_start(m_fs));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_SYNC_POL(0), .V_SYNC_POL(1),
        .WIN_X0(4), .WIN_Y0(3), .WIN_W(8), .WIN_H(5),
        .PIPE_DLY(3)
    ) u_tiny (
        .clk(clk), .rst_n(rst_n), .hsync(t_hs), .vsync(t_vs), .de(t_de),
        .win_de(t_wde), .win_x(t_wx), .win_y(t_wy), .line_start(t_ls),
        .frame_start(t_fs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected outputs of u_tiny sampled after posedge number cyc
    typedef struct {
        int          cyc;
        logic        hs;
        logic        vs;
        logic        de;
        logic        wde;
        logic [10:0] wx;
        logic [10:0] wy;
        logic        ls;
        logic        fs;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    // Measurements on the full-size instances
    int p0_hs_first = 0, p0_hs_cnt = 0, p0_de_cnt = 0, p0_de_first = 0;
    int p0_fs_cnt = 0, p0_ls_cnt = 0, p0_ls_last = 0;
    int d_hs_first = 0, d_de_first = 0, d_wde_cnt = 0, d_wxy_cnt = 0;
    int p3_hs_first = 0, p3_de_first = 0, p3_fs_first = 0;
    int m_hs_first = 0, m_hs_cnt = 0, m_de_cnt = 0, m_vs_cnt = 0;

    initial begin
        int vi;
        // cyc, hs, vs, de, wde, wx, wy, ls, fs
        vecs[0]  = '{1,   1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b1, 1'b1};
        vecs[1]  = '{2,   1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[2]  = '{4,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[3]  = '{19,  1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[4]  = '{20,  1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[5]  = '{22,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[6]  = '{24,  1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[7]  = '{25,  1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[8]  = '{26,  1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b1, 1'b0};
        vecs[9]  = '{81,  1'b1, 1'b0, 1'b1, 1'b0, 11'd1, 11'd0, 1'b0, 1'b0};
        vecs[10] = '{83,  1'b1, 1'b0, 1'b1, 1'b1, 11'd3, 11'd0, 1'b0, 1'b0};
        vecs[11] = '{87,  1'b1, 1'b0, 1'b1, 1'b1, 11'd7, 11'd0, 1'b0, 1'b0};
        vecs[12] = '{88,  1'b1, 1'b0, 1'b1, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[13] = '{91,  1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[14] = '{186, 1'b1, 1'b0, 1'b1, 1'b1, 11'd6, 11'd4, 1'b0, 1'b0};
        vecs[15] = '{207, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[16] = '{256, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[17] = '{284, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[18] = '{298, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[19] = '{328, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[20] = '{329, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[21] = '{400, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[22] = '{401, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 1'b1, 1'b1};
        vecs[23] = '{404, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};
        vecs[24] = '{481, 1'b1, 1'b0, 1'b1, 1'b0, 11'd1, 11'd0, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p0_all", {4'h0, p0_hs, p0_vs, p0_de, p0_wde, p0_wx, p0_wy, p0_ls, p0_fs},
              {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0});
        check("rst_def_sync", {29'd0, d_hs, d_vs, d_de}, {29'd0, 1'b1, 1'b1, 1'b0});
        check("rst_640_sync", {30'd0, m_hs, m_vs}, {30'd0, 1'b0, 1'b0});
        check("rst_tiny_sync", {30'd0, t_hs, t_vs}, {30'd0, 1'b1, 1'b0});

        // ---------------- free run from release ----------------
        rst_n = 1'b1;
        vi = 0;
        for (int k = 1; k <= 5133; k++) begin
            @(negedge clk);
            cyc = k;
            if (vi < NV && cyc == vecs[vi].cyc) begin
                check($sformatf("tiny_vec_k%0d", cyc),
                      {4'h0, t_hs, t_vs, t_de, t_wde, t_wx, t_wy, t_ls, t_fs},
                      {4'h0, vecs[vi].hs, vecs[vi].vs, vecs[vi].de, vecs[vi].wde,
                       vecs[vi].wx, vecs[vi].wy, vecs[vi].ls, vecs[vi].fs});
                vi++;
            end
            if (!p0_hs && p0_hs_first == 0) p0_hs_first = k;
            if (k <= 1344 && !p0_hs) p0_hs_cnt++;
            if (k <= 1344 && p0_de) p0_de_cnt++;
            if (p0_de && p0_de_first == 0) p0_de_first = k;
            if (p0_fs) p0_fs_cnt++;
            if (p0_ls) begin
                if (p0_ls_cnt > 0) check("ls_period", k - p0_ls_last, 1344);
                p0_ls_cnt++;
                p0_ls_last = k;
            end
            if (!d_hs && d_hs_first == 0) d_hs_first = k;
            if (d_de && d_de_first == 0) d_de_first = k;
            if (d_wde) d_wde_cnt++;
            if (d_wx != 11'd0 || d_wy != 11'd0) d_wxy_cnt++;
            if (!p3_hs && p3_hs_first == 0) p3_hs_first = k;
            if (p3_de && p3_de_first == 0) p3_de_first = k;
            if (p3_fs && p3_fs_first == 0) p3_fs_first = k;
            if (m_hs && m_hs_first == 0) m_hs_first = k;
            if (k <= 800 && m_hs) m_hs_cnt++;
            if (k <= 800 && m_de) m_de_cnt++;
            if (m_vs) m_vs_cnt++;
        end

        check("tiny_vectors_applied", vi, NV);
        check("p0_hs_first", p0_hs_first, 1049);
        check("p0_hs_width", p0_hs_cnt, 136);
        check("p0_de_per_line", p0_de_cnt, 1024);
        check("p0_de_first", p0_de_first, 1);
        check("p0_fs_count", p0_fs_cnt, 1);
        check("p0_ls_count", p0_ls_cnt, 4);
        check("def_hs_first", d_hs_first, 1051);
        check("def_de_first", d_de_first, 3);
        check("def_win_de_lines0_3", d_wde_cnt, 0);
        check("def_win_xy_outside", d_wxy_cnt, 0);
        check("p3_hs_shift", p3_hs_first - p0_hs_first, 3);
        check("p3_de_after_coord", p3_de_first - p3_fs_first, 3);
        check("m640_hs_first", m_hs_first, 659);
        check("m640_hs_width", m_hs_cnt, 96);
        check("m640_de_per_line", m_de_cnt, 640);
        check("m640_vs_idle", m_vs_cnt, 0);

        // ---------------- reset in the middle of an hsync pulse ----------------
        check("mid_p0_in_sync", {31'd0, p0_hs}, {31'd0, 1'b0});
        check("mid_def_in_sync", {31'd0, d_hs}, {31'd0, 1'b0});
        rst_n = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            check($sformatf("midrst_p0_%0d", r),
                  {4'h0, p0_hs, p0_vs, p0_de, p0_wde, p0_wx, p0_wy, p0_ls, p0_fs},
                  {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0});
            check($sformatf("midrst_others_%0d", r),
                  {26'd0, d_hs, d_de, p3_hs, m_hs, t_hs, t_vs},
                  {26'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_p0_k1",
              {4'h0, p0_hs, p0_vs, p0_de, p0_wde, p0_wx, p0_wy, p0_ls, p0_fs},
              {4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b1, 1'b1});
        check("rel_def_k1", {29'd0, d_hs, d_de, p3_hs}, {29'd0, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        check("rel_def_k2", {29'd0, d_hs, d_de, p3_hs}, {29'd0, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        check("rel_def_k3", {29'd0, d_hs, d_de, p3_hs}, {29'd0, 1'b1, 1'b1, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vga_timing_gen
